// File: rtl/gpu_pkg.sv
// Shared GPU definitions: cache controller state encoding and small helpers.
package gpu_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// LSU-facing and memory-controller-facing handshake signals of the data cache.
interface dcache_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) ();

  logic                 lsu_read_valid;
  logic [ADDR_BITS-1:0] lsu_read_address;
  logic                 lsu_read_ready;
  logic [DATA_BITS-1:0] lsu_read_data;
  logic                 lsu_write_valid;
  logic [ADDR_BITS-1:0] lsu_write_address;
  logic [DATA_BITS-1:0] lsu_write_data;
  logic                 lsu_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  // Cache view: serves the LSU, consumes the memory controller.
  modport slave (
    input  lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address, lsu_write_data,
    output lsu_read_ready, lsu_read_data, lsu_write_ready,
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  // Environment view: LSU requester plus memory controller.
  modport master (
    output lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address, lsu_write_data,
    input  lsu_read_ready, lsu_read_data, lsu_write_ready,
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: combinational lookup, synchronous write and clear.
module dcache_array #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_BITS-1:0]  rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_BITS-1:0]  wr_data_i
);

  localparam int NUM_LINES = 1 << INDEX_BITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] line_sel;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [DATA_BITS-1:0] data_q [NUM_LINES];

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_sel
    assign line_sel[gi] = wr_en_i && (wr_index_i == INDEX_BITS'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q | line_sel;
    end
  end

  // Tag/data need no reset: a line is only consulted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with four-phase handshakes.
module dcache
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_LINES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  output logic [7:0] hit_count,
  dcache_if.slave    bus
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [1:0]           state_q, state_d;
  logic                 served_read_q, served_read_d;
  logic [7:0]           hit_count_q, hit_count_d;
  logic                 lsu_read_ready_q, lsu_read_ready_d;
  logic [DATA_BITS-1:0] lsu_read_data_q, lsu_read_data_d;
  logic                 lsu_write_ready_q, lsu_write_ready_d;
  logic                 mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
  logic                 mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0] mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0] mem_write_data_q, mem_write_data_d;

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_BITS-1:0]  line_data;
  logic                  lookup_hit;
  logic                  mem_idle;
  logic                  arr_clear;
  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_wr_index;
  logic [TAG_BITS-1:0]   arr_wr_tag;
  logic [DATA_BITS-1:0]  arr_wr_data;

  // The single lookup port serves LSU reads in IDLE and the write-through hit test in WRITE.
  always_comb begin
    if (state_q == ST_WRITE) begin
      lookup_index = mem_write_address_q[INDEX_BITS-1:0];
      lookup_tag   = mem_write_address_q[ADDR_BITS-1:INDEX_BITS];
    end else begin
      lookup_index = bus.lsu_read_address[INDEX_BITS-1:0];
      lookup_tag   = bus.lsu_read_address[ADDR_BITS-1:INDEX_BITS];
    end
  end

  assign lookup_hit = line_valid && (line_tag == lookup_tag);
  assign mem_idle   = !bus.mem_read_ready && !bus.mem_write_ready;

  always_comb begin
    state_d             = state_q;
    served_read_d       = served_read_q;
    hit_count_d         = hit_count_q;
    lsu_read_ready_d    = lsu_read_ready_q;
    lsu_read_data_d     = lsu_read_data_q;
    lsu_write_ready_d   = lsu_write_ready_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    arr_clear           = 1'b0;
    arr_we              = 1'b0;
    arr_wr_index        = mem_read_address_q[INDEX_BITS-1:0];
    arr_wr_tag          = mem_read_address_q[ADDR_BITS-1:INDEX_BITS];
    arr_wr_data         = bus.mem_read_data;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          arr_clear = 1'b1;
        end else if (bus.lsu_read_valid) begin
          if (lookup_hit) begin
            lsu_read_data_d  = line_data;
            lsu_read_ready_d = 1'b1;
            hit_count_d      = sat_inc8(hit_count_q);
            served_read_d    = 1'b1;
            state_d          = ST_RESPOND;
          end else if (mem_idle) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = bus.lsu_read_address;
            served_read_d      = 1'b1;
            state_d            = ST_FILL;
          end
        end else if (bus.lsu_write_valid && mem_idle) begin
          mem_write_valid_d   = 1'b1;
          mem_write_address_d = bus.lsu_write_address;
          mem_write_data_d    = bus.lsu_write_data;
          served_read_d       = 1'b0;
          state_d             = ST_WRITE;
        end
      end
      ST_FILL: begin
        if (bus.mem_read_ready) begin
          arr_we           = 1'b1;
          mem_read_valid_d = 1'b0;
          lsu_read_data_d  = bus.mem_read_data;
          lsu_read_ready_d = 1'b1;
          state_d          = ST_RESPOND;
        end
      end
      ST_WRITE: begin
        if (bus.mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          lsu_write_ready_d = 1'b1;
          arr_we            = lookup_hit;
          arr_wr_index      = mem_write_address_q[INDEX_BITS-1:0];
          arr_wr_tag        = mem_write_address_q[ADDR_BITS-1:INDEX_BITS];
          arr_wr_data       = mem_write_data_q;
          state_d           = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (served_read_q) begin
          if (!bus.lsu_read_valid) begin
            lsu_read_ready_d = 1'b0;
            state_d          = ST_IDLE;
          end
        end else if (!bus.lsu_write_valid) begin
          lsu_write_ready_d = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      served_read_q       <= 1'b0;
      hit_count_q         <= '0;
      lsu_read_ready_q    <= 1'b0;
      lsu_read_data_q     <= '0;
      lsu_write_ready_q   <= 1'b0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
    end else begin
      state_q             <= state_d;
      served_read_q       <= served_read_d;
      hit_count_q         <= hit_count_d;
      lsu_read_ready_q    <= lsu_read_ready_d;
      lsu_read_data_q     <= lsu_read_data_d;
      lsu_write_ready_q   <= lsu_write_ready_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
    end
  end

  // Gating the write with reset keeps an aborted fill from installing a line.
  dcache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (arr_clear),
    .rd_index_i(lookup_index),
    .rd_valid_o(line_valid),
    .rd_tag_o  (line_tag),
    .rd_data_o (line_data),
    .wr_en_i   (arr_we && !reset),
    .wr_index_i(arr_wr_index),
    .wr_tag_i  (arr_wr_tag),
    .wr_data_i (arr_wr_data)
  );

  assign hit_count             = hit_count_q;
  assign bus.lsu_read_ready    = lsu_read_ready_q;
  assign bus.lsu_read_data     = lsu_read_data_q;
  assign bus.lsu_write_ready   = lsu_write_ready_q;
  assign bus.mem_read_valid    = mem_read_valid_q;
  assign bus.mem_read_address  = mem_read_address_q;
  assign bus.mem_write_valid   = mem_write_valid_q;
  assign bus.mem_write_address = mem_write_address_q;
  assign bus.mem_write_data    = mem_write_data_q;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: vector table for single transactions plus hand-written corner sequences.
module tb_dcache;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] hit_count;

  always #5 clk = ~clk;

  dcache_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

  dcache #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_LINES(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .hit_count(hit_count),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_model [256];
  int          mem_reads  = 0;
  int          mem_writes = 0;
  int          stab_err   = 0;
  logic [7:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory controller model: reads answer 3 cycles after valid, writes 2 cycles.
  initial begin
    int          rcnt;
    int          wcnt;
    logic [7:0]  raddr_l;
    logic [7:0]  waddr_l;
    logic [15:0] wdata_l;
    rcnt = 0; wcnt = 0; raddr_l = '0; waddr_l = '0; wdata_l = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.mem_write_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_ready) begin
        if (!bus.mem_read_valid) bus.mem_read_ready = 1'b0;
      end else if (bus.mem_read_valid) begin
        if (rcnt == 0) raddr_l = bus.mem_read_address;
        else if (bus.mem_read_address !== raddr_l) stab_err++;
        rcnt++;
        if (rcnt == 3) begin
          bus.mem_read_data  = mem_model[raddr_l];
          bus.mem_read_ready = 1'b1;
          mem_reads++;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
      if (bus.mem_write_ready) begin
        if (!bus.mem_write_valid) bus.mem_write_ready = 1'b0;
      end else if (bus.mem_write_valid) begin
        if (wcnt == 0) begin
          waddr_l = bus.mem_write_address;
          wdata_l = bus.mem_write_data;
        end else if (bus.mem_write_address !== waddr_l || bus.mem_write_data !== wdata_l) begin
          stab_err++;
        end
        wcnt++;
        if (wcnt == 2) begin
          mem_model[waddr_l]  = wdata_l;
          last_wr_addr        = waddr_l;
          last_wr_data        = wdata_l;
          bus.mem_write_ready = 1'b1;
          mem_writes++;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic lsu_read(input logic [7:0] addr, input bit flush_mid,
                          output logic [15:0] data, output int lat);
    int k;
    @(negedge clk);
    bus.lsu_read_valid   = 1'b1;
    bus.lsu_read_address = addr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      flush = (flush_mid && lat == 2);
    end while (!bus.lsu_read_ready && lat < 200);
    flush = 1'b0;
    if (lat >= 200) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=0x%0h: got no ready required ready", addr);
    end
    data = bus.lsu_read_data;
    bus.lsu_read_valid = 1'b0;
    k = 0;
    while (bus.lsu_read_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++; failures++;
      $display("FAIL read_ready_drop addr=0x%0h: got ready=1 required 0", addr);
    end
  endtask

  task automatic lsu_write(input logic [7:0] addr, input logic [15:0] wdata, output int lat);
    int k;
    @(negedge clk);
    bus.lsu_write_valid   = 1'b1;
    bus.lsu_write_address = addr;
    bus.lsu_write_data    = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.lsu_write_ready && lat < 200);
    if (lat >= 200) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=0x%0h: got no ready required ready", addr);
    end
    bus.lsu_write_valid = 1'b0;
    k = 0;
    while (bus.lsu_write_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++; failures++;
      $display("FAIL write_ready_drop addr=0x%0h: got ready=1 required 0", addr);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_mrd;
    int          exp_mwr;
    logic [7:0]  exp_hc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rdata;
    int          lat;
    int          r0;
    int          w0;

    vecs[0] = '{1'b0, 8'h2A, 16'h0000, 16'h1234, 1, 0, 8'd0};
    vecs[1] = '{1'b0, 8'h2A, 16'h0000, 16'h1234, 0, 0, 8'd1};
    vecs[2] = '{1'b1, 8'h2A, 16'hBEEF, 16'h0000, 0, 1, 8'd1};
    vecs[3] = '{1'b0, 8'h2A, 16'h0000, 16'hBEEF, 0, 0, 8'd2};
    vecs[4] = '{1'b1, 8'h13, 16'h5555, 16'h0000, 0, 1, 8'd2};
    vecs[5] = '{1'b0, 8'h13, 16'h0000, 16'h5555, 1, 0, 8'd2};
    vecs[6] = '{1'b0, 8'h02, 16'h0000, 16'h1002, 1, 0, 8'd2};
    vecs[7] = '{1'b0, 8'h0A, 16'h0000, 16'h100A, 1, 0, 8'd2};
    vecs[8] = '{1'b0, 8'h02, 16'h0000, 16'h1002, 1, 0, 8'd2};
    vecs[9] = '{1'b0, 8'h02, 16'h0000, 16'h1002, 0, 0, 8'd3};

    for (int i = 0; i < 256; i++) mem_model[i] = 16'h1000 + 16'(i);
    mem_model[8'h2A] = 16'h1234;

    reset = 1'b1;
    flush = 1'b0;
    bus.lsu_read_valid    = 1'b0;
    bus.lsu_read_address  = '0;
    bus.lsu_write_valid   = 1'b0;
    bus.lsu_write_address = '0;
    bus.lsu_write_data    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {60'(0), bus.lsu_read_ready, bus.lsu_write_ready, bus.mem_read_valid, bus.mem_write_valid}
        | {4'(0), hit_count, bus.mem_read_address, bus.mem_write_address,
           bus.mem_write_data, bus.lsu_read_data, 4'(0)}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      r0 = mem_reads;
      w0 = mem_writes;
      if (vecs[i].is_wr) begin
        lsu_write(vecs[i].addr, vecs[i].wdata, lat);
        chk($sformatf("v%0d_wr_addr", i), 64'(last_wr_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d_wr_data", i), 64'(last_wr_data), 64'(vecs[i].wdata));
      end else begin
        lsu_read(vecs[i].addr, 1'b0, rdata, lat);
        chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
        chk($sformatf("v%0d_rdata_hold", i), 64'(bus.lsu_read_data), 64'(vecs[i].exp_rdata));
        if (vecs[i].exp_mrd == 0) chk($sformatf("v%0d_hit_latency", i), 64'(lat), 64'd1);
      end
      chk($sformatf("v%0d_mem_reads", i), 64'(mem_reads - r0), 64'(vecs[i].exp_mrd));
      chk($sformatf("v%0d_mem_writes", i), 64'(mem_writes - w0), 64'(vecs[i].exp_mwr));
      chk($sformatf("v%0d_hit_count", i), 64'(hit_count), 64'(vecs[i].exp_hc));
    end

    // Flush in IDLE forces the next read to miss.
    lsu_read(8'h2A, 1'b0, rdata, lat);
    lsu_read(8'h2A, 1'b0, rdata, lat);
    chk("pre_flush_hit_count", 64'(hit_count), 64'd4);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    r0 = mem_reads;
    lsu_read(8'h2A, 1'b0, rdata, lat);
    chk("flush_miss_reads", 64'(mem_reads - r0), 64'd1);
    chk("flush_miss_data", 64'(rdata), 64'hBEEF);

    // Simultaneous read and write: the read (a hit) completes before the write is forwarded.
    w0 = mem_writes;
    @(negedge clk);
    bus.lsu_read_valid    = 1'b1;
    bus.lsu_read_address  = 8'h2A;
    bus.lsu_write_valid   = 1'b1;
    bus.lsu_write_address = 8'h30;
    bus.lsu_write_data    = 16'h7777;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.lsu_read_ready && lat < 50);
    chk("both_read_ready", 64'(bus.lsu_read_ready), 64'd1);
    chk("both_read_data", 64'(bus.lsu_read_data), 64'hBEEF);
    chk("both_write_held", 64'({bus.mem_write_valid, 8'(mem_writes - w0)}), 64'd0);
    bus.lsu_read_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.lsu_write_ready && lat < 50);
    chk("both_write_ready", 64'(bus.lsu_write_ready), 64'd1);
    chk("both_write_count", 64'(mem_writes - w0), 64'd1);
    chk("both_write_addr", 64'(last_wr_addr), 64'h30);
    bus.lsu_write_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_ready_low", 64'({bus.lsu_read_ready, bus.lsu_write_ready}), 64'd0);
    chk("both_hit_count", 64'(hit_count), 64'd5);

    // Flush pulsed during a fill is ignored: the line stays resident.
    lsu_read(8'h50, 1'b1, rdata, lat);
    chk("flush_fill_data", 64'(rdata), 64'h1050);
    r0 = mem_reads;
    lsu_read(8'h50, 1'b0, rdata, lat);
    chk("flush_ignored_reads", 64'(mem_reads - r0), 64'd0);
    chk("flush_ignored_latency", 64'(lat), 64'd1);
    chk("flush_ignored_hc", 64'(hit_count), 64'd6);

    // Reset mid-fill aborts the request and installs nothing.
    r0 = mem_reads;
    @(negedge clk);
    bus.lsu_read_valid   = 1'b1;
    bus.lsu_read_address = 8'h44;
    repeat (2) @(negedge clk);
    chk("fill_started", 64'(bus.mem_read_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_valid", 64'(bus.mem_read_valid), 64'd0);
    chk("abort_lsu_ready", 64'(bus.lsu_read_ready), 64'd0);
    chk("abort_hit_count", 64'(hit_count), 64'd0);
    bus.lsu_read_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_no_fill", 64'(mem_reads - r0), 64'd0);
    lsu_read(8'h44, 1'b0, rdata, lat);
    chk("after_abort_reads", 64'(mem_reads - r0), 64'd1);
    chk("after_abort_data", 64'(rdata), 64'h1044);
    chk("after_abort_hc", 64'(hit_count), 64'd0);

    // Hit counter saturation.
    for (int i = 0; i < 254; i++) lsu_read(8'h44, 1'b0, rdata, lat);
    chk("hc_254", 64'(hit_count), 64'd254);
    for (int i = 0; i < 6; i++) lsu_read(8'h44, 1'b0, rdata, lat);
    chk("hc_saturated", 64'(hit_count), 64'd255);

    chk("mem_addr_data_stable", 64'(stab_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: address width.
REQ-002 SHALL have parameter DATA_BITS, default 16: data width.
REQ-003 SHALL have parameter NUM_LINES, default 8: direct-mapped lines, one word each, power of two.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  invalidate all lines; honoured only in IDLE.
REQ-007 SHALL have ports lsu_read_valid  input  1 and lsu_read_address  input  ADDR_BITS: LSU read request.
REQ-008 SHALL have ports lsu_read_ready  output  1 and lsu_read_data  output  DATA_BITS: read response.
REQ-009 SHALL have ports lsu_write_valid  input  1, lsu_write_address  input  ADDR_BITS and lsu_write_data  input  DATA_BITS: LSU write request.
REQ-010 SHALL have port lsu_write_ready  output  1: write done.
REQ-011 SHALL have ports mem_read_valid  output  1, mem_read_address  output  ADDR_BITS, mem_read_ready  input  1 and mem_read_data  input  DATA_BITS: one memory-controller consumer port, read side.
REQ-012 SHALL have ports mem_write_valid  output  1, mem_write_address  output  ADDR_BITS, mem_write_data  output  DATA_BITS and mem_write_ready  input  1: memory-controller port, write side.
REQ-013 SHALL have port hit_count  output  8  saturating read-hit counter.

Function
REQ-014 SHALL split addresses as index = low log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-015 SHALL use a four-phase handshake on both sides: valid is held until ready, then dropped; ready is held until valid drops.
REQ-016 SHALL implement states IDLE, FILL, WRITE, RESPOND.
REQ-017 IDLE: flush high -> clear all valid bits, no request taken that cycle.
REQ-018 IDLE: read and write valid together -> read served first.
REQ-019 IDLE, read hit -> lsu_read_data = line data, lsu_read_ready = 1 next cycle, hit_count +1 (saturating at 255), go RESPOND; latency 1 cycle.
REQ-020 IDLE, read miss -> mem_read_valid = 1, mem_read_address = lsu_read_address, go FILL.
REQ-021 IDLE, write -> mem_write_valid = 1 with address/data, go WRITE.
REQ-022 Either downstream request SHALL be issued only when mem_read_ready and mem_write_ready are both low (previous transaction fully retired); otherwise stay IDLE.
REQ-023 FILL: mem_read_ready high -> install line (valid, tag, data), mem_read_valid = 0, lsu_read_data = mem_read_data, lsu_read_ready = 1, go RESPOND.
REQ-024 WRITE: mem_write_ready high -> mem_write_valid = 0, lsu_write_ready = 1, update the line if it is a tag hit (write-through, no-allocate), go RESPOND.
REQ-025 RESPOND: active LSU valid low -> ready = 0, go IDLE.
REQ-026 lsu_read_data SHALL hold its value until the next read response.
REQ-027 flush outside IDLE SHALL be ignored, not latched.
REQ-028 Downstream address/data SHALL stay stable while the corresponding mem valid is high.

Reset
REQ-029 On reset: state IDLE, all line valid bits 0, hit_count 0, all ready/valid outputs 0, all address/data outputs 0.
REQ-030 Reset during FILL or WRITE SHALL abort immediately, dropping mem valid next cycle, with no line installed.

Structure
REQ-031 SHALL place state encoding (IDLE/FILL/WRITE/RESPOND) in shared package gpu_pkg.
REQ-032 SHALL keep tag/valid/data arrays in one sub-module dcache_array: one combinational read port, one synchronous write port, synchronous clear.

Verification
REQ-033 Cold read 0x2A, memory returns 0x1234 after 3 cycles -> one mem read to 0x2A, lsu_read_data 0x1234, hit_count 0.
REQ-034 Repeat read 0x2A -> no mem_read_valid, ready 1 cycle after valid, data 0x1234, hit_count 1.
REQ-035 Write 0x2A = 0xBEEF, then read 0x2A -> one mem write with 0xBEEF, then a hit returning 0xBEEF; write 0x13 (line not resident) -> mem write only, next read 0x13 misses.
REQ-036 Read 0x02 then read 0x0A (same index, different tag) -> both miss, second evicts first; a third read of 0x02 misses.
REQ-037 Flush in IDLE, then read 0x2A -> miss; read and write valid in the same cycle -> read completes before the write is forwarded.
REQ-038 Reset asserted mid-FILL -> mem_read_valid 0 next cycle, line invalid, hit_count 0.
